// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM port between the IF and MEM requesters, with fixed read latency.
// Build option: define ARB_RR_EN for round-robin arbitration (default is data-over-inst priority).
module mem_port_arbiter #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_ce,
    output logic [3:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stallreq_arb
);

    typedef enum logic [0:0] {StIdle, StRdWait} state_e;

    localparam logic [2:0] CntInit = 3'(RD_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       own_q, own_d;   // 0 = inst, 1 = data
    logic       rsp_q, rsp_d;   // m_rdata is valid this cycle
    logic       can_grant;
    logic       pick_data;
    logic       d_rd_gnt;
    logic       rd_gnt;
    logic       rsp_v;

`ifdef ARB_RR_EN
    logic last_q, last_d;       // 1 = data won the most recent grant

    // On a tie, the side that did not win last goes first.
    always_comb begin
        pick_data = d_req & (~i_req | ~last_q);
        last_d    = last_q;
        if (i_gnt | d_gnt) begin
            last_d = d_gnt;
        end
    end
`else
    always_comb begin
        pick_data = d_req;
    end
`endif

    always_comb begin
        can_grant = ~cpu_rst & (state_q == StIdle);
        d_gnt     = can_grant & pick_data;
        i_gnt     = can_grant & i_req & ~pick_data;
        d_rd_gnt  = d_gnt & (d_we == 4'b0000);
        rd_gnt    = i_gnt | d_rd_gnt;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        rsp_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_gnt) begin
                    // own_q still routes any response in this same cycle
                    own_d = d_rd_gnt;
                    if (RD_LAT == 1) begin
                        rsp_d = 1'b1;
                    end else begin
                        state_d = StRdWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StRdWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StIdle;
                    rsp_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            own_q   <= 1'b0;
            rsp_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            rsp_q   <= rsp_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        m_ce    = i_gnt | d_gnt;
        m_we    = d_gnt ? d_we : 4'b0000;
        m_wdata = d_gnt ? d_wdata : '0;
        if (d_gnt) begin
            m_addr = d_addr;
        end else if (i_gnt) begin
            m_addr = i_addr;
        end else begin
            m_addr = '0;
        end
    end

    always_comb begin
        rsp_v        = rsp_q & ~cpu_rst;
        i_rvalid     = rsp_v & ~own_q;
        d_rvalid     = rsp_v & own_q;
        i_rdata      = i_rvalid ? m_rdata : '0;
        d_rdata      = d_rvalid ? m_rdata : '0;
        stallreq_arb = (i_req & ~i_gnt) | (d_req & ~d_gnt);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-stimulus bench for mem_port_arbiter at RD_LAT = 1, 2 and 7, checked against a
// cycle-budget reference model (free-at cycle, pending response, shadow memory).
module tb_mem_port_arbiter;

    int  total = 0;
    int  bad   = 0;
    logic clk;
    bit  lane_done [3];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 2 : 7);

        logic        rst, i_req, i_gnt, i_rvalid, d_req, d_gnt, d_rvalid, m_ce, stallreq;
        logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
        logic [3:0]  d_we, m_we;
        logic [31:0] emem [8];
        logic [32:0] pipe [L];

        mem_port_arbiter #(
            .RD_LAT(L),
            .ADDR_W(32),
            .DATA_W(32)
        ) u_dut (
            .cpu_clk_50M (clk),
            .cpu_rst     (rst),
            .i_req       (i_req),
            .i_addr      (i_addr),
            .i_gnt       (i_gnt),
            .i_rvalid    (i_rvalid),
            .i_rdata     (i_rdata),
            .d_req       (d_req),
            .d_we        (d_we),
            .d_addr      (d_addr),
            .d_wdata     (d_wdata),
            .d_gnt       (d_gnt),
            .d_rvalid    (d_rvalid),
            .d_rdata     (d_rdata),
            .m_ce        (m_ce),
            .m_we        (m_we),
            .m_addr      (m_addr),
            .m_wdata     (m_wdata),
            .m_rdata     (m_rdata),
            .stallreq_arb(stallreq)
        );

        // SRAM environment: read data appears L cycles after the issue cycle, junk otherwise.
        assign m_rdata = pipe[L-1][32] ? pipe[L-1][31:0] : 32'hBADC_0FFE;

        always @(posedge clk) begin
            for (int k = L - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = {m_ce && (m_we == 4'b0000), emem[m_addr[4:2]]};
            if (m_ce) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_we[b]) emem[m_addr[4:2]][8*b +: 8] = m_wdata[8*b +: 8];
                end
            end
        end

        initial begin
            logic [31:0] smem [8];
            logic [31:0] w, rsp_data;
            int          free_at, rsp_at, mode;
            bit          rsp_pend, rsp_own, last_d_win, eg_i, eg_d, pg_i, pg_d, exp_rv;
            bit          prev_rst, exp_stall;
            string       pfx;

            for (int i = 0; i < 8; i++) begin
                w       = $urandom;
                emem[i] = w;
                smem[i] = w;
            end
            for (int k = 0; k < L; k++) pipe[k] = '0;
            rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 4'b0000;
            i_addr = 32'h200; d_addr = 32'h200; d_wdata = '0;
            free_at = 0; rsp_at = 0; rsp_pend = 0; rsp_own = 0; rsp_data = '0;
            last_d_win = 0; pg_i = 0; pg_d = 0; prev_rst = 0;

            @(posedge clk); #1;
            for (int t = 0; t < 1200; t++) begin
                // mode 2: inst reads back to back, 1: both always requesting reads, 0: random
                mode = (t < 50) ? 2 : ((t < 150) ? 1 : 0);
                rst  = (t < 3) || (mode == 0 && $urandom_range(0, 59) == 0);

                if (i_req && !pg_i) begin
                    if (mode == 0 && $urandom_range(0, 15) == 0) i_req = 1'b0;
                end else begin
                    i_req = (mode != 0) || ($urandom_range(0, 1) == 1);
                    if (i_req) i_addr = 32'h200 + ($urandom_range(0, 7) << 2);
                end

                if (mode == 2) begin
                    d_req = 1'b0;
                end else if (d_req && !pg_d) begin
                    if (mode == 0 && $urandom_range(0, 15) == 0) d_req = 1'b0;
                end else begin
                    d_req = (mode == 1) || ($urandom_range(0, 1) == 1);
                    if (d_req) begin
                        d_addr  = 32'h200 + ($urandom_range(0, 7) << 2);
                        d_we    = (mode == 1 || $urandom_range(0, 1) == 1) ? 4'b0000
                                                                            : 4'($urandom_range(1, 15));
                        d_wdata = $urandom;
                    end
                end

                @(negedge clk);
                pfx  = $sformatf("L%0d t%0d ", L, t);
                eg_i = 0;
                eg_d = 0;
                if (!rst && t >= free_at) begin
                    if (d_req && i_req) begin
`ifdef ARB_RR_EN
                        eg_d = !last_d_win;
`else
                        eg_d = 1;
`endif
                    end else begin
                        eg_d = d_req;
                    end
                    eg_i = i_req && !eg_d;
                end
                exp_stall = (i_req && !eg_i) || (d_req && !eg_d);
                exp_rv    = !rst && rsp_pend && (rsp_at == t);

                check_eq({pfx, "i_gnt"}, i_gnt, eg_i);
                check_eq({pfx, "d_gnt"}, d_gnt, eg_d);
                check_eq({pfx, "stallreq"}, stallreq, exp_stall);
                check_eq({pfx, "m_ce"}, m_ce, eg_i | eg_d);
                if (rst) begin
                    check_eq({pfx, "rst m_we"}, m_we, 4'b0000);
                    check_eq({pfx, "rst m_addr"}, m_addr, 32'h0);
                    check_eq({pfx, "rst m_wdata"}, m_wdata, 32'h0);
                end else begin
                    if (eg_d) begin
                        check_eq({pfx, "d m_addr"}, m_addr, d_addr);
                        check_eq({pfx, "d m_we"}, m_we, d_we);
                        check_eq({pfx, "d m_wdata"}, m_wdata, d_wdata);
                    end else if (eg_i) begin
                        check_eq({pfx, "i m_addr"}, m_addr, i_addr);
                        check_eq({pfx, "i m_we"}, m_we, 4'b0000);
                        check_eq({pfx, "i m_wdata"}, m_wdata, 32'h0);
                    end
                    check_eq({pfx, "i_rvalid"}, i_rvalid, exp_rv && !rsp_own);
                    check_eq({pfx, "d_rvalid"}, d_rvalid, exp_rv && rsp_own);
                    if (exp_rv) begin
                        check_eq({pfx, "i_rdata"}, i_rdata, rsp_own ? 32'h0 : rsp_data);
                        check_eq({pfx, "d_rdata"}, d_rdata, rsp_own ? rsp_data : 32'h0);
                    end else if (prev_rst) begin
                        check_eq({pfx, "post-rst i_rdata"}, i_rdata, 32'h0);
                        check_eq({pfx, "post-rst d_rdata"}, d_rdata, 32'h0);
                    end
                end

                if (rst) begin
                    rsp_pend   = 0;
                    free_at    = t + 1;
                    last_d_win = 0;
                end else begin
                    if (exp_rv) rsp_pend = 0;
                    if (eg_d && d_we != 4'b0000) begin
                        for (int b = 0; b < 4; b++) begin
                            if (d_we[b]) smem[d_addr[4:2]][8*b +: 8] = d_wdata[8*b +: 8];
                        end
                        free_at = t + 1;
                    end else if (eg_i || eg_d) begin
                        rsp_pend = 1;
                        rsp_at   = t + L;
                        rsp_own  = eg_d;
                        rsp_data = eg_d ? smem[d_addr[4:2]] : smem[i_addr[4:2]];
                        free_at  = t + L;
                    end
                    if (eg_i || eg_d) last_d_win = eg_d;
                end
                pg_i     = eg_i;
                pg_d     = eg_d;
                prev_rst = rst;

                @(posedge clk); #1;
            end
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        wait (lane_done[0] && lane_done[1] && lane_done[2]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        check_eq("watchdog lanes finished", 64'd0, 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
